// File: rtl/acc_core_param.sv
// Parametrised accumulator CPU: datapath, unified RAM and fetch/decode/execute control.
// Optional macro ACC_SATURATE_EN makes ADD/SUB saturate instead of wrapping.
module acc_core_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out,
  output logic              Aeq0,
  output logic              Apos,
  output logic [ADDR_W-1:0] pc,
  output logic [2:0]        opcode,
  output logic              busy,
  output logic              halted
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned MSB   = DATA_W - 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_IN    = 3'd4;
  localparam logic [2:0] OP_JZ    = 3'd5;
  localparam logic [2:0] OP_JPOS  = 3'd6;
  localparam logic [2:0] OP_HALT  = 3'd7;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [2:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_waddr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic [DATA_W-1:0] rdata_c;
  logic [DATA_W-1:0] sum_c, diff_c, add_res_c, sub_res_c;
  logic              aeq0_c, apos_c;

  // IR is held only as its used fields: opcode and operand address
  assign rdata_c = mem_q[addr_q];
  assign sum_c   = a_q + rdata_c;
  assign diff_c  = a_q - rdata_c;
  assign aeq0_c  = (a_q == '0);
  assign apos_c  = !a_q[MSB] && !aeq0_c;

`ifdef ACC_SATURATE_EN
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic add_ovf_c, sub_ovf_c;

  // Signed overflow clamps toward the sign of A
  always_comb begin
    add_ovf_c = (a_q[MSB] == rdata_c[MSB]) && (sum_c[MSB] != a_q[MSB]);
    sub_ovf_c = (a_q[MSB] != rdata_c[MSB]) && (diff_c[MSB] != a_q[MSB]);
    add_res_c = add_ovf_c ? (a_q[MSB] ? SMIN : SMAX) : sum_c;
    sub_res_c = sub_ovf_c ? (a_q[MSB] ? SMIN : SMAX) : diff_c;
  end
`else
  always_comb begin
    add_res_c = sum_c;
    sub_res_c = diff_c;
  end
`endif

  // Next-state and datapath control
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    op_d        = op_q;
    addr_d      = addr_q;
    a_d         = a_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = prog_addr;
    mem_wdata_c = prog_data;
    case (state_q)
      S_IDLE, S_HALT: begin
        mem_we_c = prog_we;
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
        end
      end
      S_FETCH: begin
        op_d    = mem_q[pc_q][DATA_W-1 -: 3];
        addr_d  = mem_q[pc_q][ADDR_W-1:0];
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_FETCH;
        case (op_q)
          OP_LOAD:  a_d = rdata_c;
          OP_STORE: begin
            mem_we_c    = 1'b1;
            mem_waddr_c = addr_q;
            mem_wdata_c = a_q;
          end
          OP_ADD:   a_d = add_res_c;
          OP_SUB:   a_d = sub_res_c;
          OP_IN: begin
            if (in_valid) a_d = in_data;
            else          state_d = S_EXEC;
          end
          OP_JZ:    if (aeq0_c) pc_d = addr_q;
          OP_JPOS:  if (apos_c) pc_d = addr_q;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      a_q     <= a_d;
    end
  end

  // Single write port shared by STORE and program load; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
  end

  assign out      = a_q;
  assign Aeq0     = aeq0_c;
  assign Apos     = apos_c;
  assign pc       = pc_q;
  assign opcode   = op_q;
  assign busy     = (state_q == S_FETCH) || (state_q == S_DECODE) || (state_q == S_EXEC);
  assign halted   = (state_q == S_HALT);
  assign in_ready = (state_q == S_EXEC) && (op_q == OP_IN);

endmodule

// File: tb/tb_acc_core_param.sv
// Directed bench for acc_core_param with an instruction-level reference model.
module tb_acc_core_param;

  logic       clk = 1'b0;
  logic       clear, start, prog_we, in_valid;
  logic [4:0] prog_addr;
  logic [7:0] prog_data, in_data;
  logic       in_ready, Aeq0, Apos, busy, halted;
  logic [7:0] out;
  logic [4:0] pc;
  logic [2:0] opcode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  acc_core_param #(.DATA_W(8), .ADDR_W(5)) dut (
    .clk(clk), .clear(clear), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .out(out), .Aeq0(Aeq0),
    .Apos(Apos), .pc(pc), .opcode(opcode), .busy(busy), .halted(halted)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference model: ISA-level interpreter over a shadow memory
  logic [7:0] mm [32];
  logic [7:0] ma;
  logic [4:0] mpc;
  logic [7:0] model_in [$];
  logic [7:0] feed_q [$];
  int         last_n;

  function automatic logic [7:0] m_arith(input logic [7:0] x, input logic [7:0] y, input bit sub);
    int s;
    s = int'($signed(x)) + (sub ? -int'($signed(y)) : int'($signed(y)));
`ifdef ACC_SATURATE_EN
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`endif
    return 8'(s);
  endfunction

  task automatic model_run(input int maxn, output int n);
    logic [7:0] ir;
    n = 0;
    mpc = '0;
    while (n < maxn) begin
      ir  = mm[mpc];
      mpc = mpc + 5'd1;
      n++;
      case (ir[7:5])
        3'd0: ma = mm[ir[4:0]];
        3'd1: mm[ir[4:0]] = ma;
        3'd2: ma = m_arith(ma, mm[ir[4:0]], 1'b0);
        3'd3: ma = m_arith(ma, mm[ir[4:0]], 1'b1);
        3'd4: ma = model_in.pop_front();
        3'd5: if (ma == 8'd0) mpc = ir[4:0];
        3'd6: if ($signed(ma) > 0) mpc = ir[4:0];
        default: return;
      endcase
    end
  endtask

  // Architectural invariants on every cycle
  always @(negedge clk) begin
    if (!clear) begin
      chk("flag_eq0", Aeq0, out == 8'd0);
      chk("flag_pos", Apos, $signed(out) > 0);
      chk("busy_halt_excl", busy & halted, 0);
      chk("ready_needs_busy", in_ready & !busy, 0);
    end
  end

  task automatic load(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
    mm[a] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    ma = '0;
  endtask

  // Start the core, feed IN words from feed_q (after 'delay' stall cycles), wait for HALT
  task automatic run_prog(input int budget, input int delay, output int cyc);
    int waited;
    bit hs;
    logic [7:0] hold_out;
    logic [4:0] hold_pc;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0; waited = 0; hs = 1'b0;
    hold_out = '0; hold_pc = '0;
    while (!halted && cyc < budget) begin
      in_valid = 1'b0;
      if (in_ready) begin
        if (waited < delay) begin
          if (waited == 0) begin
            hold_out = out; hold_pc = pc;
          end else begin
            chk("stall_out", out, hold_out);
            chk("stall_pc", pc, hold_pc);
            chk("stall_busy", busy, 1);
          end
          waited++;
        end else if (feed_q.size() > 0) begin
          in_valid = 1'b1;
          in_data  = feed_q[0];
          hs = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
      if (hs) begin
        chk("hs_a", out, in_data);
        chk("hs_ready_drop", in_ready, 0);
        void'(feed_q.pop_front());
        hs = 1'b0; waited = 0;
      end
    end
    in_valid = 1'b0;
    if (!halted) chk("halt_timeout", 0, 1);
  endtask

  task automatic check_run(input string nm, input int delay);
    int n, cyc;
    model_in = feed_q;
    model_run(64, n);
    run_prog(200, delay, cyc);
    chk({nm, "_out"}, out, ma);
    chk({nm, "_pc"}, pc, mpc);
    chk({nm, "_halted"}, halted, 1);
    chk({nm, "_cycles"}, cyc, 3 * n + delay);
    last_n = n;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    clear = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    in_data = '0; in_valid = 1'b0; ma = '0; mpc = '0; last_n = 0;
    repeat (2) @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_pc", pc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_aeq0", Aeq0, 1);
    clear = 1'b0;
    for (int i = 0; i < 32; i++) load(5'(i), 8'h00);
    chk("idle_busy", busy, 0);

    // Countdown from 3
    load(0, 8'h80); load(1, 8'h7E); load(2, 8'hA4); load(3, 8'hC1); load(4, 8'hE0);
    load(30, 8'h01);
    feed_q = '{8'h03};
    check_run("countdown", 0);
    chk("countdown_lit_out", out, 8'h00);
    chk("countdown_lit_pc", pc, 5);
    chk("countdown_lit_aeq0", Aeq0, 1);
    chk("countdown_model_n", last_n, 10);

    // Load/store round trip through RAM[20]
    load(0, 8'h80); load(1, 8'h34); load(2, 8'h15); load(3, 8'h14); load(4, 8'hE0);
    load(21, 8'h00);
    feed_q = '{8'h25};
    check_run("ldst", 0);
    chk("ldst_lit_out", out, 8'h25);
    chk("ldst_model_mem20", mm[20], 8'h25);

    // IN handshake with a 5-cycle stall
    load(0, 8'h80); load(1, 8'hE0);
    feed_q = '{8'h5A};
    check_run("hshake", 5);
    chk("hshake_lit_out", out, 8'h5A);
    chk("hshake_lit_pc", pc, 2);

    // Overflow / underflow edges
    load(1, 8'h4A); load(2, 8'hE0); load(10, 8'h01);
    feed_q = '{8'h7F};
    check_run("add_ovf", 0);
`ifdef ACC_SATURATE_EN
    chk("add_ovf_lit", out, 8'h7F);
`else
    chk("add_ovf_lit", out, 8'h80);
`endif
    load(1, 8'h6A);
    feed_q = '{8'h80};
    check_run("sub_unf", 0);
`ifdef ACC_SATURATE_EN
    chk("sub_unf_lit", out, 8'h80);
`else
    chk("sub_unf_lit", out, 8'h7F);
`endif
    load(1, 8'h4B); load(11, 8'h90);
    feed_q = '{8'h90};
    check_run("add_neg_ovf", 0);
`ifdef ACC_SATURATE_EN
    chk("add_neg_ovf_lit", out, 8'h80);
`else
    chk("add_neg_ovf_lit", out, 8'h20);
`endif
    load(1, 8'h4C); load(2, 8'h6D); load(3, 8'hE0); load(12, 8'hFE); load(13, 8'h05);
    feed_q = '{8'h05};
    check_run("arith_plain", 0);
    chk("arith_plain_lit", out, 8'hFE);
    chk("arith_plain_apos", Apos, 0);

    // Guards: prog_we and start ignored while busy
    load(0, 8'h80); load(1, 8'hE0); load(25, 8'h11);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!in_ready && guard < 20) begin @(negedge clk); guard++; end
    chk("guard_reach_in", in_ready, 1);
    prog_we = 1'b1; prog_addr = 5'd25; prog_data = 8'h99; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    chk("guard_no_restart_pc", pc, 1);
    chk("guard_still_in", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h33;
    @(negedge clk);
    in_valid = 1'b0;
    guard = 0;
    while (!halted && guard < 20) begin @(negedge clk); guard++; end
    chk("guard_halted", halted, 1);
    chk("guard_out", out, 8'h33);
    chk("guard_pc", pc, 2);
    ma = 8'h33;
    load(0, 8'h19);
    feed_q = '{};
    check_run("guard_mem25", 0);
    chk("guard_mem25_lit", out, 8'h11);

    // clear during EXECUTE of STORE loses the write
    load(0, 8'h80); load(1, 8'h3A); load(2, 8'hE0); load(26, 8'h22);
    in_valid = 1'b1; in_data = 8'h77;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    while (!(busy && opcode == 3'd1) && guard < 20) begin @(negedge clk); guard++; end
    in_valid = 1'b0;
    @(negedge clk);
    chk("clr_pre_out", out, 8'h77);
    chk("clr_pre_busy", busy, 1);
    #1 clear = 1'b1;
    #1;
    chk("clr_out", out, 0);
    chk("clr_pc", pc, 0);
    chk("clr_busy", busy, 0);
    chk("clr_halted", halted, 0);
    @(negedge clk);
    clear = 1'b0;
    ma = '0;
    repeat (3) @(negedge clk);
    chk("clr_stays_idle", busy | halted, 0);
    load(0, 8'h1A); load(1, 8'hE0);
    check_run("clr_mem26", 0);
    chk("clr_mem26_lit", out, 8'h22);

    // PC wrap from 31 to 0
    do_reset();
    load(0, 8'hBF); load(1, 8'hE0); load(31, 8'h40);
    check_run("wrap", 0);
    chk("wrap_lit_out", out, 8'hBF);
    chk("wrap_lit_pc", pc, 2);
    chk("wrap_model_n", last_n, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
